pixel_frame_writer: RTL
=======================

Name: pixel_frame_writer

Overview:
- Receiving end of the plot/x/y/colour pixel-write interface driven by the image-drawing datapaths.
- Converts each plot strobe into an address (y*WIDTH + x) and writes the colour into an internal 160x120 frame buffer RAM.
- Provides a pipelined read-back port for collision and hit checks.
- Provides a hardware clear sequencer that fills the whole buffer with one colour.

Parameters:
- WIDTH, 160, pixels per row.
- HEIGHT, 120, rows per frame.
- COLOUR_BITS, 3, bits per pixel.
- CLEAR_COLOUR, 3'b000, value written by the clear sequence.

Ports:
- clk  in  1  system clock (CLOCK_50 at top level).
- resetn  in  1  synchronous active-low reset.
- plot  in  1  pixel write request.
- x  in  8  write column.
- y  in  7  write row.
- colour  in  COLOUR_BITS  write data.
- ready  out  1  write port can accept; a plot is taken only when plot && ready.
- clear_start  in  1  one-cycle request to fill the buffer.
- busy  out  1  clear sequence in progress.
- clear_done  out  1  one-cycle pulse when the clear completes.
- rd_req  in  1  read request.
- rd_x  in  8  read column.
- rd_y  in  7  read row.
- rd_valid  out  1  read data valid.
- rd_colour  out  COLOUR_BITS  read data.
- oob_err  out  1  one-cycle pulse when an out-of-range write is dropped.
- wr_count  out  16  accepted in-range pixel writes.

Behaviour:
- Reset: one clock, synchronous, active-low. While resetn=0 at a rising edge:
  - FSM goes to IDLE; pipeline valids clear.
  - busy=0, clear_done=0, rd_valid=0, rd_colour=0, oob_err=0, wr_count=0.
  - ready=1 from the first cycle after reset (ready = state==IDLE).
  - RAM contents are not reset.
- FSM states:
  - IDLE: clear_start -> CLEAR.
  - CLEAR: after address WIDTH*HEIGHT-1 is issued -> IDLE.
  - clear_start while in CLEAR is ignored.
- Write pipeline, plot accepted at edge N:
  - S1 at N+1: register addr = y*WIDTH + x (15-bit). Range check is x<WIDTH && y<HEIGHT.
  - Out-of-range: write dropped, oob_err=1 for the cycle after N+1, wr_count unchanged.
  - S2 at N+2: RAM write. Reads issued at or after N+2 see the new data.
  - wr_count increments at N+1 for in-range writes and saturates at 16'hFFFF.
- Back-to-back writes sustain one per cycle; the last write to an address wins.
- Clear sequence:
  - Clear addresses 0..19199 enter S1 one per cycle through the same S2 write path, so earlier plots always land before clear writes.
  - busy=1 for the whole CLEAR state (19200 cycles). ready=0, and plot is ignored, not queued.
  - clear_done pulses one cycle, in the cycle after the final clear address enters S1.
  - wr_count resets to 0 when the clear starts.
- Simultaneous plot && clear_start in IDLE: the plot is accepted and the clear starts next cycle. Net effect: that pixel ends as CLEAR_COLOUR.
- Read pipeline, rd_req at edge N:
  - Address registered at N+1.
  - rd_valid=1 and rd_colour valid during cycle N+2.
  - One read per cycle, including during CLEAR.
  - A read and a write to the same address in the same cycle returns the old data (read-before-write).
  - Out-of-range read: rd_valid=1, rd_colour=0.
- Reset mid-clear: aborts to IDLE. busy=0, no clear_done pulse, buffer partially cleared.

Optional Feature:
- Macro: TRANSPARENT_SKIP_EN.
- Defined: plots with colour==0 are accepted (ready handshake unchanged) but are not written to RAM and do not increment wr_count. Sprites are drawn with black as transparent; clear writes are unaffected.
- Undefined: every in-range plot writes RAM, including colour 0.

Decomposition:
- Shared package holds:
  - FB_WIDTH=160, FB_HEIGHT=120, FB_DEPTH=19200, FB_ADDR_W=15, COLOUR_W=3.
  - The FSM state encoding typedef (IDLE, CLEAR).
  - The colour constant BLACK=3'b000.
- One sub-module: fb_ram, a simple dual-port synchronous RAM with one write port, one registered read port and read-before-write. It infers block RAM.

Test Plan:
- Reset, plot x=5 y=2 colour=3'b110, then rd_req at (5,2) 3 cycles later -> rd_valid 2 cycles after rd_req, rd_colour=3'b110, wr_count=1.
- Plot (159,119)=3'b001, then (160,0)=3'b111 -> first stored at addr 19199. Second dropped, with an oob_err pulse and wr_count=1.
- Write (10,10)=3'b010 at edge N and read (10,10) at edge N+1 -> returns old value. A read at N+2 returns 3'b010.
- clear_start with CLEAR_COLOUR=0 -> busy high 19200 cycles, ready=0, plots ignored. clear_done is a one-cycle pulse; afterwards reads at (0,0) and (159,119) return 0 and wr_count=0.
- Reset asserted 100 cycles into a clear -> busy=0 next cycle, no clear_done, (0,0) cleared, (159,119) retains its old value.
- With TRANSPARENT_SKIP_EN: pre-write (3,3)=3'b101, then plot (3,3)=0 -> read returns 3'b101 and wr_count is unchanged. Without the macro, the read returns 0.

Source files
------------

// File: rtl/pixel_frame_writer_pkg.sv
// Shared constants, FSM encoding and address helper for the pixel frame writer.
package pixel_frame_writer_pkg;

    localparam int FB_WIDTH  = 160;
    localparam int FB_HEIGHT = 120;
    localparam int FB_DEPTH  = 19200;
    localparam int FB_ADDR_W = 15;
    localparam int COLOUR_W  = 3;

    localparam logic [COLOUR_W-1:0] BLACK = 3'b000;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } fb_state_t;

    // Linear frame-buffer address of pixel (px, py): py*width + px.
    function automatic logic [FB_ADDR_W-1:0] fb_addr(
        input logic [7:0]  px,
        input logic [6:0]  py,
        input int unsigned width
    );
        logic [FB_ADDR_W-1:0] row_base;
        row_base = FB_ADDR_W'(py) * FB_ADDR_W'(width);
        return row_base + FB_ADDR_W'(px);
    endfunction

endpackage

// File: rtl/pixel_frame_writer_fb_ram.sv
// Simple dual-port frame-buffer RAM: one write port, one registered read
// port. A read and a write to the same address on the same edge return the
// old contents. Contents are deliberately not reset so it maps to block RAM.
module fb_ram
    import pixel_frame_writer_pkg::*;
#(
    parameter int DEPTH  = FB_DEPTH,
    parameter int ADDR_W = FB_ADDR_W,
    parameter int DATA_W = COLOUR_W
) (
    input  logic              clk,
    input  logic              wr_en_s,
    input  logic [ADDR_W-1:0] wr_addr_s,
    input  logic [DATA_W-1:0] wr_data_s,
    input  logic [ADDR_W-1:0] rd_addr_s,
    output logic [DATA_W-1:0] rd_data_r
);

    logic [DATA_W-1:0] mem_r [DEPTH];

    // Write port.
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            mem_r[wr_addr_s] <= wr_data_s;
        end
    end

    // Registered read port; sees the pre-write value on a same-edge collision.
    always_ff @(posedge clk) begin
        rd_data_r <= mem_r[rd_addr_s];
    end

endmodule

// File: rtl/pixel_frame_writer.sv
// Pixel frame writer: turns plot/x/y/colour strobes into frame-buffer writes,
// offers a two-cycle read-back port and a whole-buffer clear sequencer.
// Optional build macro TRANSPARENT_SKIP_EN: plots with colour 0 are accepted
// but neither written nor counted (black is transparent for sprites).
module pixel_frame_writer
    import pixel_frame_writer_pkg::*;
#(
    parameter int                     WIDTH        = FB_WIDTH,
    parameter int                     HEIGHT       = FB_HEIGHT,
    parameter int                     COLOUR_BITS  = COLOUR_W,
    parameter logic [COLOUR_BITS-1:0] CLEAR_COLOUR = COLOUR_BITS'(BLACK)
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic                   plot,
    input  logic [7:0]             x,
    input  logic [6:0]             y,
    input  logic [COLOUR_BITS-1:0] colour,
    output logic                   ready,
    input  logic                   clear_start,
    output logic                   busy,
    output logic                   clear_done,
    input  logic                   rd_req,
    input  logic [7:0]             rd_x,
    input  logic [6:0]             rd_y,
    output logic                   rd_valid,
    output logic [COLOUR_BITS-1:0] rd_colour,
    output logic                   oob_err,
    output logic [15:0]            wr_count
);

    localparam logic [7:0]           X_LIM     = 8'(WIDTH);
    localparam logic [6:0]           Y_LIM     = 7'(HEIGHT);
    localparam logic [FB_ADDR_W-1:0] LAST_ADDR = FB_ADDR_W'(WIDTH * HEIGHT - 1);

    fb_state_t              state_r;
    fb_state_t              state_next_s;
    logic                   ready_s;
    logic                   busy_s;
    logic                   clr_issue_s;
    logic                   clr_last_s;
    logic                   clear_take_s;
    logic [FB_ADDR_W-1:0]   clr_addr_r;

    logic                   plot_take_s;
    logic                   wr_in_range_s;
    logic                   skip_s;
    logic                   wr_commit_s;
    logic [FB_ADDR_W-1:0]   wr_addr_s;

    logic                   s1_we_r;
    logic [FB_ADDR_W-1:0]   s1_addr_r;
    logic [COLOUR_BITS-1:0] s1_colour_r;

    logic                   oob_err_r;
    logic [15:0]            wr_count_r;
    logic                   clear_done_r;

    logic                   rd_in_range_s;
    logic [FB_ADDR_W-1:0]   rd_addr_s;
    logic [COLOUR_BITS-1:0] ram_rd_data_s;
    logic                   rd_v1_r;
    logic                   rd_ok1_r;
    logic                   rd_valid_r;
    logic [COLOUR_BITS-1:0] rd_colour_r;

    // Write-side decode: range check, linear address and acceptance.
    assign wr_in_range_s = (x < X_LIM) && (y < Y_LIM);
    assign wr_addr_s     = fb_addr(x, y, WIDTH);
    assign plot_take_s   = plot && ready_s;
    assign clear_take_s  = clear_start && ready_s;
    assign clr_last_s    = (clr_addr_r == LAST_ADDR);

`ifdef TRANSPARENT_SKIP_EN
    assign skip_s = (colour == {COLOUR_BITS{1'b0}});
`else
    assign skip_s = 1'b0;
`endif

    assign wr_commit_s = plot_take_s && wr_in_range_s && !skip_s;

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // FSM next-state logic; a clear_start during CLEAR is ignored.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (clear_start) begin
                    state_next_s = ST_CLEAR;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_CLEAR: begin
                if (clr_last_s) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_CLEAR;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // FSM outputs: handshake, busy flag and clear-address issue enable.
    always_comb begin
        ready_s     = 1'b0;
        busy_s      = 1'b0;
        clr_issue_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                ready_s = 1'b1;
            end
            ST_CLEAR: begin
                busy_s      = 1'b1;
                clr_issue_s = 1'b1;
            end
            default: begin
                ready_s     = 1'b0;
                busy_s      = 1'b0;
                clr_issue_s = 1'b0;
            end
        endcase
    end

    // Clear address counter, one address per CLEAR cycle.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            clr_addr_r <= {FB_ADDR_W{1'b0}};
        end else if (clr_issue_s && !clr_last_s) begin
            clr_addr_r <= clr_addr_r + FB_ADDR_W'(1);
        end else begin
            clr_addr_r <= {FB_ADDR_W{1'b0}};
        end
    end

    // S1 stage: shared by plots and clear addresses so ordering is preserved.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            s1_we_r     <= 1'b0;
            s1_addr_r   <= {FB_ADDR_W{1'b0}};
            s1_colour_r <= {COLOUR_BITS{1'b0}};
        end else if (clr_issue_s) begin
            s1_we_r     <= 1'b1;
            s1_addr_r   <= clr_addr_r;
            s1_colour_r <= CLEAR_COLOUR;
        end else begin
            s1_we_r     <= wr_commit_s;
            s1_addr_r   <= wr_addr_s;
            s1_colour_r <= colour;
        end
    end

    // Status registers: drop pulse, accepted-write counter, clear completion.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            oob_err_r    <= 1'b0;
            wr_count_r   <= 16'd0;
            clear_done_r <= 1'b0;
        end else begin
            oob_err_r    <= plot_take_s && !wr_in_range_s;
            clear_done_r <= clr_issue_s && clr_last_s;
            if (clear_take_s) begin
                wr_count_r <= 16'd0;
            end else if (wr_commit_s && (wr_count_r != 16'hFFFF)) begin
                wr_count_r <= wr_count_r + 16'd1;
            end else begin
                wr_count_r <= wr_count_r;
            end
        end
    end

    // Read-side decode; out-of-range reads use address 0 and are masked later.
    assign rd_in_range_s = (rd_x < X_LIM) && (rd_y < Y_LIM);
    assign rd_addr_s     = rd_in_range_s ? fb_addr(rd_x, rd_y, WIDTH)
                                         : {FB_ADDR_W{1'b0}};

    fb_ram #(
        .DEPTH  (WIDTH * HEIGHT),
        .ADDR_W (FB_ADDR_W),
        .DATA_W (COLOUR_BITS)
    ) u_fb_ram (
        .clk       (clk),
        .wr_en_s   (s1_we_r),
        .wr_addr_s (s1_addr_r),
        .wr_data_s (s1_colour_r),
        .rd_addr_s (rd_addr_s),
        .rd_data_r (ram_rd_data_s)
    );

    // Read pipeline: track request alongside the RAM access, then register output.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            rd_v1_r     <= 1'b0;
            rd_ok1_r    <= 1'b0;
            rd_valid_r  <= 1'b0;
            rd_colour_r <= {COLOUR_BITS{1'b0}};
        end else begin
            rd_v1_r    <= rd_req;
            rd_ok1_r   <= rd_req && rd_in_range_s;
            rd_valid_r <= rd_v1_r;
            if (rd_ok1_r) begin
                rd_colour_r <= ram_rd_data_s;
            end else begin
                rd_colour_r <= {COLOUR_BITS{1'b0}};
            end
        end
    end

    assign ready      = ready_s;
    assign busy       = busy_s;
    assign clear_done = clear_done_r;
    assign oob_err    = oob_err_r;
    assign wr_count   = wr_count_r;
    assign rd_valid   = rd_valid_r;
    assign rd_colour  = rd_colour_r;

endmodule
